regfile_arbiter: RTL and testbench
==================================

// Module: regfile_arbiter
// PURPOSE
//  Owns the REGCOUNT x 8-bit configuration register file and shares its single write port
//  between two requesters: the I2C slave (host writes) and the parallel-input capture path.
//  Round-robin arbitration; per-request error flagging; a lock bit that blocks parallel writes.
//  Drives registers_packed to the IO output block; provides a combinational read port.
// PARAMETERS
//  REGCOUNT   20            number of 8-bit registers
//  AW         5             address width, clog2(REGCOUNT)
//  LOCK_ADDR  REGCOUNT-1    register whose bit0 locks out parallel-path writes
// PORTS
//  clock             in   1            system clock
//  reset             in   1            synchronous, active-high
//  i2c_req           in   1            I2C write request, held until i2c_gnt
//  i2c_addr          in   AW           I2C target register
//  i2c_wdata         in   8            I2C write data
//  i2c_gnt           out  1            1-cycle grant pulse; write commits this cycle
//  par_req           in   1            parallel write request, held until par_gnt
//  par_addr          in   AW           parallel target register
//  par_wdata         in   8            parallel write data
//  par_gnt           out  1            1-cycle grant pulse
//  wr_err            out  1            pulses with gnt when the granted write is discarded
//  rd_addr           in   AW           read address
//  rd_data           out  8            comb. read data; 8'h00 if rd_addr >= REGCOUNT
//  registers_packed  out  8*REGCOUNT   reg k at bits [8k+7:8k]
//  reject_count      out  8            saturating count of discarded writes
// BEHAVIOUR
//  Reset: all registers 8'h00, FSM=IDLE, i2c_gnt=par_gnt=wr_err=0, reject_count=0,
//   last_winner=PAR (so I2C wins the first tie). Reset mid-grant aborts the write.
//  FSM states IDLE, GNT_I2C, GNT_PAR:
//   IDLE: no req -> IDLE. One req -> GNT_x. Both -> GNT to requester != last_winner.
//   GNT_x: gnt_x=1 (registered from state), write evaluated, last_winner<=x, -> IDLE always.
//  Throughput: max one write per 2 cycles; req seen in cycle N -> gnt in N+1 -> data visible
//   in registers_packed/rd_data at N+2. Requester drops req at N+2; IDLE ignores a req only
//   if deasserted; a still-high req at N+2 is treated as a new request.
//  Addr/data sampled in the GNT cycle; requester must hold them stable from req to gnt.
//  Discard rules (checked in GNT cycle, wr_err=1, no register change):
//   - addr >= REGCOUNT (either requester)
//   - par write while reg[LOCK_ADDR][0]==1
//   I2C may always write LOCK_ADDR, including clearing the lock.
//  reject_count += 1 on each discard; saturates at 8'hFF, no wrap.
//  Starvation bound: with both reqs held continuously, grants alternate I2C,PAR,I2C...
//  rd_data and registers_packed are pure functions of the register array (no extra latency).
// STRUCTURE
//  chip_pkg: REGCOUNT, AW, LOCK_ADDR constants; typedef enum {IDLE,GNT_I2C,GNT_PAR} arb_state_t;
//   typedef enum logic {REQ_I2C,REQ_PAR} req_id_t.
//  Sub-module rr_pick2: 2-way round-robin pick (req[1:0], last_winner -> winner); comb only.
//  Register array, discard logic, counter and FSM live in regfile_arbiter.
// TESTING
//  1 reset, then i2c write addr 3 data 8'hA5 -> i2c_gnt 1 cycle later, reg3=8'hA5 next cycle, wr_err=0.
//  2 both req same cycle from reset (i2c a=1 d=11, par a=2 d=22) -> I2C granted first, PAR next grant;
//    reg1=8'h11, reg2=8'h22; held reqs thereafter alternate grants.
//  3 i2c writes LOCK_ADDR=8'h01, then par write a=5 d=8'h77 -> par_gnt with wr_err=1, reg5 unchanged,
//    reject_count=1; i2c writes LOCK_ADDR=8'h00, par retry -> reg5=8'h77.
//  4 i2c write addr 25 -> i2c_gnt+wr_err, no register changes; rd_addr=25 -> rd_data=8'h00.
//  5 force 260 discarded writes -> reject_count stops at 8'hFF.
//  6 assert reset during GNT_PAR cycle -> write not committed, all regs 0, gnts low next cycle.

Source files
------------

// File: rtl/regfile_arbiter_pkg.sv
// Shared constants and types for the configuration register file and its
// two-requester write arbiter.
package regfile_arbiter_pkg;

  localparam int REGCOUNT  = 20;
  localparam int AW        = 5;
  localparam int LOCK_ADDR = REGCOUNT - 1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GNT_I2C = 2'd1,
    GNT_PAR = 2'd2
  } arb_state_t;

  typedef enum logic {
    REQ_I2C = 1'b0,
    REQ_PAR = 1'b1
  } req_id_t;

endpackage

// File: rtl/regfile_arbiter_rr_pick2.sv
// Two-way round-robin picker: a lone requester wins outright, and on a tie the
// requester that did not win last time is chosen.
module rr_pick2
  import regfile_arbiter_pkg::*;
(
  input  logic [1:0] req,
  input  req_id_t    last_winner,
  output logic       valid,
  output req_id_t    winner
);

  // req[0] is the I2C slave, req[1] is the parallel capture path.
  always_comb begin
    valid  = |req;
    winner = REQ_I2C;
    case (req)
      2'b01:   winner = REQ_I2C;
      2'b10:   winner = REQ_PAR;
      2'b11:   winner = (last_winner == REQ_I2C) ? REQ_PAR : REQ_I2C;
      default: winner = REQ_I2C;
    endcase
  end

endmodule

// File: rtl/regfile_arbiter.sv
// Configuration register file with a single write port shared between the I2C
// slave and the parallel capture path; writes commit at the end of the grant cycle.
module regfile_arbiter
  import regfile_arbiter_pkg::*;
(
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  i2c_req,
  input  logic [AW-1:0]         i2c_addr,
  input  logic [7:0]            i2c_wdata,
  output logic                  i2c_gnt,
  input  logic                  par_req,
  input  logic [AW-1:0]         par_addr,
  input  logic [7:0]            par_wdata,
  output logic                  par_gnt,
  output logic                  wr_err,
  input  logic [AW-1:0]         rd_addr,
  output logic [7:0]            rd_data,
  output logic [8*REGCOUNT-1:0] registers_packed,
  output logic [7:0]            reject_count
);

  localparam logic [1:0]  ST_IDLE    = IDLE;
  localparam logic [1:0]  ST_GNT_I2C = GNT_I2C;
  localparam logic [1:0]  ST_GNT_PAR = GNT_PAR;
  localparam logic [AW:0] REG_LIMIT  = (AW+1)'(REGCOUNT);

  logic [7:0]    regs [REGCOUNT];
  logic [1:0]    state_reg, state_next;
  req_id_t       last_winner_reg;
  logic [7:0]    reject_count_reg;

  logic          pick_valid;
  req_id_t       pick_winner;

  logic          in_grant;
  logic [AW-1:0] wr_addr;
  logic [7:0]    wr_data;
  logic          addr_bad;
  logic          locked;
  logic          discard;

  rr_pick2 u_pick (
    .req         ({par_req, i2c_req}),
    .last_winner (last_winner_reg),
    .valid       (pick_valid),
    .winner      (pick_winner)
  );

  always_comb begin
    state_next = ST_IDLE;
    case (state_reg)
      ST_IDLE: begin
        if (pick_valid)
          state_next = (pick_winner == REQ_I2C) ? ST_GNT_I2C : ST_GNT_PAR;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  assign i2c_gnt  = (state_reg == ST_GNT_I2C);
  assign par_gnt  = (state_reg == ST_GNT_PAR);
  assign in_grant = i2c_gnt | par_gnt;

  // Address and data are taken from whichever requester holds the grant.
  assign wr_addr  = par_gnt ? par_addr  : i2c_addr;
  assign wr_data  = par_gnt ? par_wdata : i2c_wdata;
  assign addr_bad = ({1'b0, wr_addr} >= REG_LIMIT);
  assign locked   = regs[LOCK_ADDR][0];
  assign discard  = in_grant & (addr_bad | (par_gnt & locked));
  assign wr_err   = discard;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg        <= ST_IDLE;
      last_winner_reg  <= REQ_PAR;
      reject_count_reg <= 8'h00;
      for (int k = 0; k < REGCOUNT; k++)
        regs[k] <= 8'h00;
    end else begin
      state_reg <= state_next;
      if (i2c_gnt)
        last_winner_reg <= REQ_I2C;
      else if (par_gnt)
        last_winner_reg <= REQ_PAR;
      if (in_grant && !discard)
        regs[wr_addr] <= wr_data;
      if (discard && reject_count_reg != 8'hFF)
        reject_count_reg <= reject_count_reg + 8'h01;
    end
  end

  assign reject_count = reject_count_reg;

  always_comb begin
    rd_data = 8'h00;
    if ({1'b0, rd_addr} < REG_LIMIT)
      rd_data = regs[rd_addr];
  end

  generate
    for (genvar gi = 0; gi < REGCOUNT; gi++) begin : g_pack
      assign registers_packed[8*gi +: 8] = regs[gi];
    end
  endgenerate

endmodule

// File: tb/tb_regfile_arbiter.sv
// Self-checking bench for regfile_arbiter: directed scenarios plus randomized
// two-requester traffic checked against a transaction-level register model.
module tb_regfile_arbiter;
  import regfile_arbiter_pkg::*;

  logic                  clock = 1'b0;
  logic                  reset;
  logic                  i2c_req, par_req;
  logic [AW-1:0]         i2c_addr, par_addr, rd_addr;
  logic [7:0]            i2c_wdata, par_wdata;
  logic                  i2c_gnt, par_gnt, wr_err;
  logic [7:0]            rd_data, reject_count;
  logic [8*REGCOUNT-1:0] registers_packed;

  int         n_tests = 0;
  int         n_fail  = 0;
  logic [7:0] m_regs [REGCOUNT];
  int         m_rej;
  bit         m_last_par;

  regfile_arbiter dut (
    .clock(clock), .reset(reset),
    .i2c_req(i2c_req), .i2c_addr(i2c_addr), .i2c_wdata(i2c_wdata), .i2c_gnt(i2c_gnt),
    .par_req(par_req), .par_addr(par_addr), .par_wdata(par_wdata), .par_gnt(par_gnt),
    .wr_err(wr_err), .rd_addr(rd_addr), .rd_data(rd_data),
    .registers_packed(registers_packed), .reject_count(reject_count)
  );

  always #5 clock = ~clock;

  function automatic void model_reset();
    for (int k = 0; k < REGCOUNT; k++) m_regs[k] = 8'h00;
    m_rej      = 0;
    m_last_par = 1'b1;
  endfunction

  // Applies one granted write to the model and returns whether it is discarded.
  function automatic bit model_apply(bit is_par, logic [AW-1:0] a, logic [7:0] d);
    bit err;
    err = (int'(a) >= REGCOUNT) || (is_par && m_regs[LOCK_ADDR][0]);
    if (err) begin
      if (m_rej < 255) m_rej++;
    end else begin
      m_regs[int'(a)] = d;
    end
    m_last_par = is_par;
    return err;
  endfunction

  function automatic logic [8*REGCOUNT-1:0] model_packed();
    logic [8*REGCOUNT-1:0] v;
    for (int k = 0; k < REGCOUNT; k++) v[8*k +: 8] = m_regs[k];
    return v;
  endfunction

  function automatic logic [7:0] model_read(logic [AW-1:0] a);
    if (int'(a) >= REGCOUNT) return 8'h00;
    return m_regs[int'(a)];
  endfunction

  task automatic apply_reset();
    reset = 1'b1; i2c_req = 1'b0; par_req = 1'b0;
    i2c_addr = '0; par_addr = '0; i2c_wdata = '0; par_wdata = '0; rd_addr = '0;
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;
    model_reset();
  endtask

  // Single-requester write; returns at the cycle after the grant (data visible).
  task automatic do_write(input bit is_par, input logic [AW-1:0] a, input logic [7:0] d,
                          output bit granted, output bit err, output bit other, output int lat);
    granted = 1'b0; err = 1'b0; other = 1'b0; lat = 0;
    if (is_par) begin par_addr = a; par_wdata = d; par_req = 1'b1; end
    else        begin i2c_addr = a; i2c_wdata = d; i2c_req = 1'b1; end
    while (!granted && lat < 6) begin
      @(posedge clock); #1;
      lat++;
      granted = is_par ? par_gnt : i2c_gnt;
    end
    err   = wr_err;
    other = is_par ? i2c_gnt : par_gnt;
    i2c_req = 1'b0; par_req = 1'b0;
    @(posedge clock); #1;
  endtask

  task automatic test_reset();
    apply_reset();
    #1;
    n_tests++;
    if (i2c_gnt !== 1'b0 || par_gnt !== 1'b0 || wr_err !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_outputs: gnt_i2c=%b gnt_par=%b wr_err=%b required 0 0 0", i2c_gnt, par_gnt, wr_err);
    end
    n_tests++;
    if (reject_count !== 8'h00 || registers_packed !== '0) begin
      n_fail++;
      $display("FAIL reset_state: reject_count=%h regs=%h required all zero", reject_count, registers_packed);
    end
  endtask

  task automatic test_single_write();
    bit g, e, o; int lat; bit exp_e;
    do_write(1'b0, 5'd3, 8'hA5, g, e, o, lat);
    exp_e = model_apply(1'b0, 5'd3, 8'hA5);
    n_tests++;
    if (!g || lat != 1 || o) begin
      n_fail++;
      $display("FAIL single_latency: granted=%b latency=%0d other_gnt=%b required 1 1 0", g, lat, o);
    end
    n_tests++;
    if (e !== exp_e) begin
      n_fail++;
      $display("FAIL single_err: wr_err=%b required %b", e, exp_e);
    end
    rd_addr = 5'd3; #1;
    n_tests++;
    if (rd_data !== 8'hA5 || registers_packed !== model_packed()) begin
      n_fail++;
      $display("FAIL single_data: rd_data=%h regs=%h required %h / %h", rd_data, registers_packed, 8'hA5, model_packed());
    end
    $display("[TB] single write addr 3 data a5 latency %0d", lat);
  endtask

  task automatic test_tie();
    int wait_c; bit exp_par; bit exp_e; bit timed_out;
    i2c_addr = 5'd1; i2c_wdata = 8'h11; par_addr = 5'd2; par_wdata = 8'h22;
    i2c_req = 1'b1; par_req = 1'b1;
    timed_out = 1'b0;
    for (int g = 0; g < 6 && !timed_out; g++) begin
      wait_c = 0;
      do begin
        @(posedge clock); #1;
        wait_c++;
      end while (!(i2c_gnt || par_gnt) && wait_c < 4);
      exp_par = !m_last_par;
      n_tests++;
      if (!(i2c_gnt || par_gnt)) begin
        n_fail++; timed_out = 1'b1;
        $display("FAIL tie_timeout: no grant within 4 cycles on grant %0d", g);
      end else if (par_gnt !== exp_par || i2c_gnt !== !exp_par || wait_c != (g == 0 ? 1 : 2)) begin
        n_fail++;
        $display("FAIL tie_order: grant %0d i2c=%b par=%b after %0d cycles required par=%b after %0d",
                 g, i2c_gnt, par_gnt, wait_c, exp_par, (g == 0 ? 1 : 2));
      end
      if (!timed_out) begin
        exp_e = model_apply(exp_par, exp_par ? par_addr : i2c_addr, exp_par ? par_wdata : i2c_wdata);
        n_tests++;
        if (wr_err !== exp_e) begin
          n_fail++;
          $display("FAIL tie_err: grant %0d wr_err=%b required %b", g, wr_err, exp_e);
        end
        $display("[TB] tie grant %0d to %s", g, exp_par ? "par" : "i2c");
      end
    end
    i2c_req = 1'b0; par_req = 1'b0;
    @(posedge clock); #1;
    n_tests++;
    if (registers_packed[15:8] !== 8'h11 || registers_packed[23:16] !== 8'h22) begin
      n_fail++;
      $display("FAIL tie_data: reg1=%h reg2=%h required 11 22", registers_packed[15:8], registers_packed[23:16]);
    end
  endtask

  task automatic test_lock();
    bit g, e, o; int lat; bit exp_e;
    do_write(1'b0, 5'(LOCK_ADDR), 8'h01, g, e, o, lat);
    void'(model_apply(1'b0, 5'(LOCK_ADDR), 8'h01));
    do_write(1'b1, 5'd5, 8'h77, g, e, o, lat);
    exp_e = model_apply(1'b1, 5'd5, 8'h77);
    n_tests++;
    if (!g || e !== 1'b1 || exp_e !== 1'b1) begin
      n_fail++;
      $display("FAIL lock_discard: granted=%b wr_err=%b required 1 1", g, e);
    end
    n_tests++;
    if (registers_packed[47:40] !== 8'h00 || reject_count !== 8'h01) begin
      n_fail++;
      $display("FAIL lock_state: reg5=%h reject_count=%h required 00 01", registers_packed[47:40], reject_count);
    end
    do_write(1'b0, 5'(LOCK_ADDR), 8'h00, g, e, o, lat);
    void'(model_apply(1'b0, 5'(LOCK_ADDR), 8'h00));
    do_write(1'b1, 5'd5, 8'h77, g, e, o, lat);
    exp_e = model_apply(1'b1, 5'd5, 8'h77);
    n_tests++;
    if (e !== exp_e || registers_packed[47:40] !== 8'h77) begin
      n_fail++;
      $display("FAIL unlock_retry: wr_err=%b reg5=%h required %b 77", e, registers_packed[47:40], exp_e);
    end
    $display("[TB] lock/unlock sequence done, reject_count %0d", reject_count);
  endtask

  task automatic test_bad_addr();
    bit g, e, o; int lat;
    do_write(1'b0, 5'd25, 8'h5A, g, e, o, lat);
    void'(model_apply(1'b0, 5'd25, 8'h5A));
    n_tests++;
    if (!g || e !== 1'b1 || registers_packed !== model_packed() || reject_count !== 8'(m_rej)) begin
      n_fail++;
      $display("FAIL bad_addr: granted=%b wr_err=%b rej=%0d regs=%h required 1 1 %0d %h",
               g, e, reject_count, registers_packed, m_rej, model_packed());
    end
    rd_addr = 5'd25; #1;
    n_tests++;
    if (rd_data !== 8'h00) begin
      n_fail++;
      $display("FAIL rd_out_of_range: rd_data=%h required 00", rd_data);
    end
    rd_addr = 5'd20; #1;
    n_tests++;
    if (rd_data !== 8'h00) begin
      n_fail++;
      $display("FAIL rd_boundary: rd_data=%h required 00", rd_data);
    end
  endtask

  task automatic test_random();
    bit pend_i, pend_p, exp_par, exp_e, stop; int wait_c; logic [1:0] mask;
    for (int it = 0; it < 60; it++) begin
      mask      = 2'(($urandom_range(2, 0)) + 1);
      i2c_addr  = ($urandom_range(3, 0) == 0) ? 5'(LOCK_ADDR) : 5'($urandom_range(23, 0));
      i2c_wdata = 8'($urandom);
      par_addr  = 5'($urandom_range(23, 0));
      par_wdata = 8'($urandom);
      pend_i = mask[0]; pend_p = mask[1];
      i2c_req = pend_i; par_req = pend_p;
      stop = 1'b0;
      while ((pend_i || pend_p) && !stop) begin
        wait_c = 0;
        do begin
          @(posedge clock); #1;
          wait_c++;
        end while (!(i2c_gnt || par_gnt) && wait_c < 4);
        exp_par = (pend_i && pend_p) ? !m_last_par : pend_p;
        n_tests++;
        if (!(i2c_gnt || par_gnt)) begin
          n_fail++; stop = 1'b1;
          $display("FAIL rand_timeout: iter %0d no grant within 4 cycles", it);
        end else if (par_gnt !== exp_par || i2c_gnt !== !exp_par) begin
          n_fail++;
          $display("FAIL rand_order: iter %0d i2c=%b par=%b required par=%b", it, i2c_gnt, par_gnt, exp_par);
        end
        if (!stop) begin
          exp_e = model_apply(exp_par, exp_par ? par_addr : i2c_addr, exp_par ? par_wdata : i2c_wdata);
          n_tests++;
          if (wr_err !== exp_e) begin
            n_fail++;
            $display("FAIL rand_err: iter %0d wr_err=%b required %b", it, wr_err, exp_e);
          end
          if (exp_par) begin par_req = 1'b0; pend_p = 1'b0; end
          else         begin i2c_req = 1'b0; pend_i = 1'b0; end
        end
      end
      i2c_req = 1'b0; par_req = 1'b0;
      @(posedge clock); #1;
      rd_addr = 5'($urandom_range(31, 0)); #1;
      n_tests++;
      if (registers_packed !== model_packed() || reject_count !== 8'(m_rej) || rd_data !== model_read(rd_addr)) begin
        n_fail++;
        $display("FAIL rand_state: iter %0d rej=%0d rd[%0d]=%h regs=%h required %0d %h %h",
                 it, reject_count, rd_addr, rd_data, registers_packed, m_rej, model_read(rd_addr), model_packed());
      end
      $display("[TB] random iter %0d mask %b reject_count %0d", it, mask, reject_count);
    end
  endtask

  task automatic test_saturate();
    bit g, e, o; int lat; logic [AW-1:0] a;
    for (int k = 0; k < 260; k++) begin
      a = 5'($urandom_range(31, 20));
      do_write(1'b0, a, 8'($urandom), g, e, o, lat);
      void'(model_apply(1'b0, a, 8'h00));
      n_tests++;
      if (!g || e !== 1'b1 || reject_count !== 8'(m_rej)) begin
        n_fail++;
        $display("FAIL saturate_step: write %0d granted=%b wr_err=%b rej=%0d required 1 1 %0d",
                 k, g, e, reject_count, m_rej);
      end
    end
    n_tests++;
    if (reject_count !== 8'hFF) begin
      n_fail++;
      $display("FAIL saturate_final: reject_count=%h required ff", reject_count);
    end
    $display("[TB] 260 discarded writes, reject_count %h", reject_count);
  endtask

  task automatic test_reset_mid_grant();
    bit g, e, o; int lat; int wait_c;
    do_write(1'b0, 5'(LOCK_ADDR), 8'h00, g, e, o, lat);
    void'(model_apply(1'b0, 5'(LOCK_ADDR), 8'h00));
    do_write(1'b0, 5'd7, 8'h33, g, e, o, lat);
    void'(model_apply(1'b0, 5'd7, 8'h33));
    par_addr = 5'd4; par_wdata = 8'h99; par_req = 1'b1;
    wait_c = 0;
    do begin
      @(posedge clock); #1;
      wait_c++;
    end while (!par_gnt && wait_c < 4);
    n_tests++;
    if (par_gnt !== 1'b1) begin
      n_fail++;
      $display("FAIL midgrant_gnt: par_gnt=%b required 1", par_gnt);
    end
    reset = 1'b1; par_req = 1'b0;
    @(posedge clock); #1;
    n_tests++;
    if (registers_packed !== '0 || i2c_gnt !== 1'b0 || par_gnt !== 1'b0 || wr_err !== 1'b0 || reject_count !== 8'h00) begin
      n_fail++;
      $display("FAIL midgrant_reset: regs=%h gnt=%b%b wr_err=%b rej=%h required all zero",
               registers_packed, i2c_gnt, par_gnt, wr_err, reject_count);
    end
    @(posedge clock); #1 reset = 1'b0;
    model_reset();
    rd_addr = 5'd4;
    @(posedge clock); #1;
    n_tests++;
    if (rd_data !== 8'h00) begin
      n_fail++;
      $display("FAIL midgrant_reg4: rd_data=%h required 00", rd_data);
    end
    $display("[TB] reset during par grant, reg4 %h", rd_data);
  endtask

  initial begin
    test_reset();
    test_single_write();
    test_tie();
    test_lock();
    test_bad_addr();
    test_random();
    test_saturate();
    test_reset_mid_grant();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
